// File: rtl/nbr_reward_engine_if.sv
// Shared word-memory bus between the reward engine and the neighbour RAM.
// Read data returns one cycle after the address is presented.
interface nbr_reward_engine_if #(
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 11
);
  logic [ADDR_WIDTH-1:0] address;
  logic                  wr_en;
  logic [WORD_WIDTH-1:0] mem_data_in;
  logic [WORD_WIDTH-1:0] mem_data_out;

  modport master (
    output address,
    output wr_en,
    output mem_data_in,
    input  mem_data_out
  );

  modport slave (
    input  address,
    input  wr_en,
    input  mem_data_in,
    output mem_data_out
  );
endinterface

// File: rtl/nbr_reward_engine.sv
// Neighbour table search/update/insert engine with saturating reward.
// Each table entry is four words: ID, battery, value, cluster.
module nbr_reward_engine #(
  parameter int          WORD_WIDTH    = 16,
  parameter int          ADDR_WIDTH    = 11,
  parameter int          MAX_NBR       = 8,
  parameter int          BASE_ADDR     = 0,
  parameter int          FRAC_BITS     = 15,
  parameter int unsigned CLUSTER_BONUS = 32'h0100
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  mode,
  input  logic [WORD_WIDTH-1:0] my_clusterID,
  input  logic [WORD_WIDTH-1:0] fsourceID,
  input  logic [WORD_WIDTH-1:0] fbatteryStat,
  input  logic [WORD_WIDTH-1:0] fValue,
  input  logic [WORD_WIDTH-1:0] fclusterID,
  input  logic [WORD_WIDTH-1:0] fdestinationID,
  nbr_reward_engine_if.master   mem,
  output logic [WORD_WIDTH-1:0] reward_out,
  output logic                  done_reward,
  output logic                  busy,
  output logic                  hit,
  output logic                  drop,
  output logic [$clog2(MAX_NBR+1)-1:0] nbr_count
);

  localparam int CW = $clog2(MAX_NBR+1);
  localparam int PW = 2*WORD_WIDTH;
  localparam logic [CW-1:0] MAX_C = CW'(MAX_NBR);

  typedef enum logic [2:0] {
    IDLE,
    SEARCH_RD,
    SEARCH_CMP,
    WRITE,
    COMPUTE,
    DONE
  } state_t;

  state_t state;

  logic [WORD_WIDTH-1:0] id_q;
  logic [WORD_WIDTH-1:0] bat_q;
  logic [WORD_WIDTH-1:0] val_q;
  logic [WORD_WIDTH-1:0] clu_q;
  logic [WORD_WIDTH-1:0] myc_q;
  logic [WORD_WIDTH-1:0] unused_dest_q;
  logic                  mode_q;
  logic                  found;
  logic                  full;
  logic [CW-1:0]         idx;
  logic [CW-1:0]         idx_nx;
  logic [CW-1:0]         wslot;
  logic [1:0]            woff;

  logic [PW-1:0]         prod;
  logic [PW-1:0]         scaled;
  logic [PW-1:0]         bonus;
  logic [PW:0]           sum;
  logic [WORD_WIDTH-1:0] reward;

  assign busy   = (state != IDLE);
  assign idx_nx = idx + CW'(1);

  assign prod   = PW'(val_q) * PW'(bat_q);
  assign scaled = prod >> FRAC_BITS;
  assign bonus  = (clu_q == myc_q) ? PW'(CLUSTER_BONUS) : '0;
  assign sum    = {1'b0, scaled} + {1'b0, bonus};
  assign reward = (|sum[PW:WORD_WIDTH]) ? '1
                                        : sum[WORD_WIDTH-1:0];

  function automatic logic [ADDR_WIDTH-1:0] slot_addr(
    input logic [CW-1:0] i,
    input logic [1:0]    off
  );
    return ADDR_WIDTH'(BASE_ADDR) + {(ADDR_WIDTH-2)'(i), off};
  endfunction

  function automatic logic [WORD_WIDTH-1:0] word_at(
    input logic [1:0] off
  );
    logic [WORD_WIDTH-1:0] w;
    unique case (off)
      2'd0:    w = id_q;
      2'd1:    w = bat_q;
      2'd2:    w = val_q;
      default: w = clu_q;
    endcase
    return w;
  endfunction

  always_ff @(posedge clock) begin
    if (!nrst) begin
      state           <= IDLE;
      nbr_count       <= '0;
      reward_out      <= '0;
      done_reward     <= 1'b0;
      hit             <= 1'b0;
      drop            <= 1'b0;
      mem.address     <= '0;
      mem.wr_en       <= 1'b0;
      mem.mem_data_in <= '0;
      id_q            <= '0;
      bat_q           <= '0;
      val_q           <= '0;
      clu_q           <= '0;
      myc_q           <= '0;
      unused_dest_q   <= '0;
      mode_q          <= 1'b0;
      found           <= 1'b0;
      full            <= 1'b0;
      idx             <= '0;
      wslot           <= '0;
      woff            <= '0;
    end else begin
      done_reward <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en) begin
            id_q          <= fsourceID;
            bat_q         <= fbatteryStat;
            val_q         <= fValue;
            clu_q         <= fclusterID;
            myc_q         <= my_clusterID;
            unused_dest_q <= fdestinationID;
            mode_q        <= mode;
            found         <= 1'b0;
            full          <= 1'b0;
            idx           <= '0;
            if (nbr_count != '0) begin
              mem.address <= slot_addr('0, 2'd0);
              state       <= SEARCH_RD;
            end else if (mode) begin
              wslot           <= '0;
              woff            <= 2'd0;
              mem.address     <= slot_addr('0, 2'd0);
              mem.mem_data_in <= fsourceID;
              mem.wr_en       <= 1'b1;
              state           <= WRITE;
            end else begin
              state <= COMPUTE;
            end
          end
        end
        SEARCH_RD: state <= SEARCH_CMP;
        SEARCH_CMP: begin
          if (mem.mem_data_out == id_q) begin
            found <= 1'b1;
            if (mode_q) begin
              wslot           <= idx;
              woff            <= 2'd1;
              mem.address     <= slot_addr(idx, 2'd1);
              mem.mem_data_in <= bat_q;
              mem.wr_en       <= 1'b1;
              state           <= WRITE;
            end else begin
              state <= COMPUTE;
            end
          end else if (idx_nx < nbr_count) begin
            idx         <= idx_nx;
            mem.address <= slot_addr(idx_nx, 2'd0);
            state       <= SEARCH_RD;
          end else if (mode_q && nbr_count < MAX_C) begin
            wslot           <= nbr_count;
            woff            <= 2'd0;
            mem.address     <= slot_addr(nbr_count, 2'd0);
            mem.mem_data_in <= id_q;
            mem.wr_en       <= 1'b1;
            state           <= WRITE;
          end else begin
            full  <= mode_q;
            state <= COMPUTE;
          end
        end
        WRITE: begin
          if (woff == 2'd3) begin
            mem.wr_en <= 1'b0;
            state     <= COMPUTE;
            // only a fresh insert grows the table
            if (!found)
              nbr_count <= nbr_count + CW'(1);
          end else begin
            woff            <= woff + 2'd1;
            mem.address     <= slot_addr(wslot, woff + 2'd1);
            mem.mem_data_in <= word_at(woff + 2'd1);
          end
        end
        COMPUTE: begin
          reward_out  <= reward;
          hit         <= found;
          drop        <= full;
          done_reward <= 1'b1;
          state       <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nbr_reward_engine.sv
// Directed bench for nbr_reward_engine: table model, write scoreboard
// and per-cycle output comparison against a request-level model.
module tb_nbr_reward_engine;
  localparam int WW   = 16;
  localparam int AW   = 11;
  localparam int MAXN = 8;
  localparam int BASE = 0;
  localparam int CW   = $clog2(MAXN+1);

  logic clock = 1'b0;
  logic nrst  = 1'b0;
  logic en    = 1'b0;
  logic mode  = 1'b0;
  logic [WW-1:0] my_clusterID   = '0;
  logic [WW-1:0] fsourceID      = '0;
  logic [WW-1:0] fbatteryStat   = '0;
  logic [WW-1:0] fValue         = '0;
  logic [WW-1:0] fclusterID     = '0;
  logic [WW-1:0] fdestinationID = '0;
  logic [WW-1:0] reward_out;
  logic          done_reward;
  logic          busy;
  logic          hit;
  logic          drop;
  logic [CW-1:0] nbr_count;

  nbr_reward_engine_if #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW)) bus();

  nbr_reward_engine #(
    .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .MAX_NBR(MAXN),
    .BASE_ADDR(BASE), .FRAC_BITS(15), .CLUSTER_BONUS(32'h0100)
  ) dut (
    .clock(clock), .nrst(nrst), .en(en), .mode(mode),
    .my_clusterID(my_clusterID), .fsourceID(fsourceID),
    .fbatteryStat(fbatteryStat), .fValue(fValue),
    .fclusterID(fclusterID), .fdestinationID(fdestinationID),
    .mem(bus), .reward_out(reward_out),
    .done_reward(done_reward), .busy(busy), .hit(hit),
    .drop(drop), .nbr_count(nbr_count)
  );

  always #5 clock = ~clock;

  logic [WW-1:0] ram [0:(1<<AW)-1];
  initial for (int i = 0; i < (1<<AW); i++) ram[i] = '0;
  always @(posedge clock) begin
    if (bus.wr_en) ram[bus.address] <= bus.mem_data_in;
    bus.mem_data_out <= ram[bus.address];
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // request-level model: table contents and expected results
  int m_id [MAXN];
  int m_bat[MAXN];
  int m_val[MAXN];
  int m_clu[MAXN];
  int m_cnt = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [WW-1:0] d;
  } wr_t;
  wr_t wq[$];

  bit active = 1'b0;
  int cyc = 0;
  int c0, exp_done, last_lat;
  int e_rew;
  bit e_hit, e_drop;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    wr_t w;
    #1;
    chk("busy", busy, active);
    if (bus.wr_en) begin
      if (wq.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        w = wq.pop_front();
        chk("wr_addr", bus.address, w.a);
        chk("wr_data", bus.mem_data_in, w.d);
      end
    end
    if (done_reward) begin
      if (!active) chk("unexpected_done", 1, 0);
      else begin
        last_lat = cyc - c0;
        chk("done_cycle", cyc, exp_done);
        chk("reward", reward_out, e_rew);
        chk("hit", hit, e_hit);
        chk("drop", drop, e_drop);
        chk("nbr_count", nbr_count, m_cnt);
        chk("writes_left", wq.size(), 0);
        active = 1'b0;
      end
    end else if (active && cyc > exp_done) begin
      chk("done_late", cyc, exp_done);
      active = 1'b0;
    end
  end

  task automatic issue(bit md, int id, int bat, int val,
                       int clu, int myc);
    int k, p_n, w_n, slot;
    longint r;
    int ent[4];
    @(negedge clock);
    mode           = md;
    fsourceID      = WW'(id);
    fbatteryStat   = WW'(bat);
    fValue         = WW'(val);
    fclusterID     = WW'(clu);
    my_clusterID   = WW'(myc);
    fdestinationID = WW'($urandom);
    en             = 1'b1;
    k = -1;
    for (int i = 0; i < m_cnt; i++)
      if (k < 0 && m_id[i] == id) k = i;
    p_n    = (k >= 0) ? k + 1 : m_cnt;
    w_n    = 0;
    e_hit  = (k >= 0);
    e_drop = 1'b0;
    ent    = '{id, bat, val, clu};
    if (md) begin
      if (k >= 0 || m_cnt < MAXN) begin
        slot = (k >= 0) ? k : m_cnt;
        for (int o = (k >= 0) ? 1 : 0; o < 4; o++) begin
          wq.push_back('{a: AW'(BASE + 4*slot + o), d: WW'(ent[o])});
          w_n++;
        end
        m_id[slot]  = id;
        m_bat[slot] = bat;
        m_val[slot] = val;
        m_clu[slot] = clu;
        if (k < 0) m_cnt++;
      end else begin
        e_drop = 1'b1;
      end
    end
    r = (longint'(val) * longint'(bat)) / 32768;
    if (clu == myc) r = r + 256;
    if (r > 65535) r = 65535;
    e_rew    = int'(r);
    c0       = cyc + 1;
    exp_done = c0 + 2*p_n + w_n + 1;
    active   = 1'b1;
  endtask

  task automatic junk();
    mode         = 1'($urandom);
    fsourceID    = WW'($urandom);
    fbatteryStat = WW'($urandom);
    fValue       = WW'($urandom);
    fclusterID   = WW'($urandom);
    my_clusterID = WW'($urandom);
  endtask

  task automatic wait_done(bit hold);
    int n = 0;
    @(negedge clock);
    en = hold;
    if (hold) junk();
    while (active && n < 300) begin
      @(negedge clock);
      if (hold) junk();
      n++;
    end
    if (active) begin
      chk("timeout", 0, 1);
      active = 1'b0;
      wq.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    nrst = 1'b0;
    en   = 1'b0;
    active = 1'b0;
    wq.delete();
    m_cnt = 0;
    repeat (2) @(negedge clock);
    nrst = 1'b1;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_wr_en"}, bus.wr_en, 0);
    chk({tag, "_addr"}, bus.address, 0);
    chk({tag, "_wdata"}, bus.mem_data_in, 0);
    chk({tag, "_reward"}, reward_out, 0);
    chk({tag, "_done"}, done_reward, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_hit"}, hit, 0);
    chk({tag, "_drop"}, drop, 0);
    chk({tag, "_cnt"}, nbr_count, 0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk_zero("rst");
    nrst = 1'b1;

    // empty-table insert
    issue(1, 15, 'h4000, 'h0680, 1, 1);
    chk("pin_model_r1", e_rew, 'h0440);
    wait_done(0);
    chk("t1_reward", reward_out, 'h0440);
    chk("t1_lat", last_lat, 5);
    chk("t1_hit", hit, 0);
    chk("t1_cnt", nbr_count, 1);
    chk("t1_m0", ram[0], 15);
    chk("t1_m1", ram[1], 'h4000);
    chk("t1_m2", ram[2], 'h0680);
    chk("t1_m3", ram[3], 1);

    // table {3,7,15} then update 15
    do_reset();
    issue(1, 3, 'h1000, 'h0200, 5, 1);  wait_done(0);
    issue(1, 7, 'h3000, 'h0400, 6, 1);  wait_done(0);
    issue(1, 15, 'h7000, 'h0800, 1, 1); wait_done(0);
    issue(1, 15, 'h2000, 'h0680, 2, 1);
    chk("pin_model_r2", e_rew, 'h01A0);
    wait_done(0);
    chk("t2_reward", reward_out, 'h01A0);
    chk("t2_lat", last_lat, 10);
    chk("t2_hit", hit, 1);
    chk("t2_cnt", nbr_count, 3);
    chk("t2_m9", ram[9], 'h2000);

    // fill the table, then a refused insert
    for (int i = 0; i < 5; i++) begin
      issue(1, 100 + i, 'h0100 * (i + 1), 'h0300, i, 2);
      wait_done(0);
    end
    issue(1, 200, 'h4000, 'h1000, 1, 1);
    wait_done(0);
    chk("t3_drop", drop, 1);
    chk("t3_hit", hit, 0);
    chk("t3_lat", last_lat, 17);
    chk("t3_cnt", nbr_count, MAXN);
    chk("t3_reward", reward_out, 'h0900);

    // saturating lookup, then a lookup miss
    issue(0, 7, 'hFFFF, 'hFFFF, 3, 3);
    wait_done(0);
    chk("t4_reward", reward_out, 'hFFFF);
    chk("t4_hit", hit, 1);
    issue(0, 999, 'h8000, 'h0002, 3, 4);
    wait_done(0);
    chk("t5_drop", drop, 0);

    // en held through busy and DONE, then a new request
    issue(0, 3, 'h8000, 'h0100, 4, 4);
    wait_done(1);
    issue(1, 104, 'h1234, 'h5678, 4, 9);
    wait_done(0);

    for (int i = 0; i < MAXN; i++) begin
      chk("tbl_id",  ram[BASE + 4*i],     m_id[i]);
      chk("tbl_bat", ram[BASE + 4*i + 1], m_bat[i]);
      chk("tbl_val", ram[BASE + 4*i + 2], m_val[i]);
      chk("tbl_clu", ram[BASE + 4*i + 3], m_clu[i]);
    end

    // reset in the middle of an insert
    do_reset();
    issue(1, 42, 'h4000, 'h0100, 1, 1);
    repeat (2) @(negedge clock);
    chk("mid_writes_left", wq.size(), 2);
    nrst   = 1'b0;
    en     = 1'b0;
    active = 1'b0;
    wq.delete();
    m_cnt  = 0;
    @(negedge clock);
    chk_zero("mid");
    @(negedge clock);
    nrst = 1'b1;
    repeat (6) @(negedge clock);
    chk("mid_idle_cnt", nbr_count, 0);
    issue(1, 42, 'h4000, 'h0100, 1, 1);
    wait_done(0);
    chk("post_cnt", nbr_count, 1);

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
